// File: rtl/usb_rx_buffer.sv
// usb_rx_buffer: packet-aware receive FIFO between the USB receiver and the
// AHB slave. Captures DATA bytes of a packet, tracks framing (start, done,
// error) and offers a pop-style read port with a registered head byte.
// Optional feature: define USB_RX_BUF_OVERFLOW_FLAG_EN to get a sticky
// overflow flag that also turns an overflowed packet's EOP into an error.
module usb_rx_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    rx_packet,
    input  logic          store_rx_packet,
    input  logic [7:0]    rx_packet_data,
    input  logic          get_rx_data,
    input  logic          clear,
    output logic [7:0]    rx_data,
    output logic [AW:0]   buffer_occupancy,
    output logic          rx_data_ready,
    output logic          rx_transfer_active,
    output logic          rx_error,
    output logic          rx_overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        PKT_NONE       = 3'd0,
        PKT_IN         = 3'd1,
        PKT_OUT        = 3'd2,
        PKT_DATA_START = 3'd3,
        PKT_DATA       = 3'd4,
        PKT_ACK        = 3'd5,
        PKT_EOP        = 3'd6,
        PKT_ERR        = 3'd7
    } pkt_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE,
        S_ERROR
    } state_e;

    logic [7:0]    r_mem [DEPTH];
    state_e        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic [7:0]    r_rx_data;
    logic          r_ready;
    logic          r_active;
    logic          r_error;

    pkt_e          w_code;
    logic          w_start;
    logic          w_data;
    logic          w_eop;
    logic          w_err_pkt;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_flush;
    logic          w_fwd;
    state_e        w_next_state;
    logic [AW-1:0] w_rd_next;
    logic [AW:0]   w_occ_after_pop;
    logic [AW:0]   w_occ_next;

    assign w_code          = pkt_e'(rx_packet);
    assign w_start         = store_rx_packet && (w_code == PKT_DATA_START);
    assign w_data          = store_rx_packet && (w_code == PKT_DATA);
    assign w_eop           = store_rx_packet && (w_code == PKT_EOP);
    assign w_err_pkt       = store_rx_packet && (w_code == PKT_ERR);
    assign w_full          = (r_occ == FULL_COUNT);
    assign w_empty         = (r_occ == '0);
    assign w_pop           = get_rx_data && !w_empty;
    assign w_wr_en         = (r_state == S_RECV) && w_data && !w_full;
    assign w_occ_after_pop = r_occ - (AW+1)'(w_pop);
    assign w_occ_next      = w_flush ? '0 : (w_occ_after_pop + (AW+1)'(w_wr_en));
    // A flush discards stored bytes by catching the read pointer up to the
    // write pointer, so pointers keep wrapping across packets.
    assign w_rd_next       = w_flush ? r_wr_ptr : (r_rd_ptr + AW'(w_pop));
    // Popping onto the slot being written this cycle: bypass the memory.
    assign w_fwd           = w_wr_en && w_pop && (r_wr_ptr == w_rd_next);

`ifdef USB_RX_BUF_OVERFLOW_FLAG_EN
    logic r_overflow;
    logic w_ovf_hit;
    assign w_ovf_hit   = (r_state == S_RECV) && w_data && w_full;
    assign rx_overflow = r_overflow;
`else
    assign rx_overflow = 1'b0;
`endif

    // Packet framing: next state and flush decision
    always_comb begin
        w_next_state = r_state;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_RECV;
                    w_flush      = 1'b1;
                end
            end
            S_RECV: begin
                if (w_start) begin
                    w_flush = 1'b1;
                end else if (w_eop) begin
`ifdef USB_RX_BUF_OVERFLOW_FLAG_EN
                    if (r_overflow) begin
                        w_next_state = S_ERROR;
                        w_flush      = 1'b1;
                    end else begin
                        w_next_state = S_DONE;
                    end
`else
                    w_next_state = S_DONE;
`endif
                end else if (w_err_pkt) begin
                    w_next_state = S_ERROR;
                    w_flush      = 1'b1;
                end
            end
            S_DONE: begin
                if (w_start) begin
                    w_next_state = S_RECV;
                    w_flush      = 1'b1;
                end else if (w_occ_after_pop == '0) begin
                    w_next_state = S_IDLE;
                end
            end
            S_ERROR: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Byte storage (no reset needed, occupancy qualifies contents)
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= rx_packet_data;
    end

    // FSM, pointers, occupancy and registered status outputs
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_rx_data <= '0;
            r_ready   <= 1'b0;
            r_active  <= 1'b0;
            r_error   <= 1'b0;
`ifdef USB_RX_BUF_OVERFLOW_FLAG_EN
            r_overflow <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_wr_ptr  <= r_wr_ptr + AW'(w_wr_en);
            r_rd_ptr  <= w_rd_next;
            r_occ     <= w_occ_next;
            r_rx_data <= w_flush ? '0 : (w_fwd ? rx_packet_data : r_mem[w_rd_next]);
            r_ready   <= (w_next_state == S_DONE) && (w_occ_next != '0);
            r_active  <= (w_next_state == S_RECV);
            if ((w_next_state == S_ERROR) && (r_state != S_ERROR))
                r_error <= 1'b1;
            else if (w_start && (r_state != S_ERROR))
                r_error <= 1'b0;
`ifdef USB_RX_BUF_OVERFLOW_FLAG_EN
            if (w_start && (r_state != S_ERROR))
                r_overflow <= 1'b0;
            else if (w_ovf_hit)
                r_overflow <= 1'b1;
`endif
        end
    end

    assign rx_data            = r_rx_data;
    assign buffer_occupancy   = r_occ;
    assign rx_data_ready      = r_ready;
    assign rx_transfer_active = r_active;
    assign rx_error           = r_error;

endmodule
